// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per result producer, round-robin
// grant among occupied buffers, one registered broadcast per running cycle.
module cdb_arbiter #(
    parameter int unsigned RoB_WIDTH = 3,
    parameter int unsigned NUM_REQ   = 3
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           RoB_flush_signal,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*RoB_WIDTH-1:0]   req_rob_index,
    input  logic [NUM_REQ*32-1:0]          req_data,
    input  logic [NUM_REQ*32-1:0]          req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cdb_valid,
    output logic [RoB_WIDTH-1:0]           cdb_rob_index,
    output logic [31:0]                    cdb_data,
    output logic [31:0]                    cdb_addr,
    output logic [1:0]                     cdb_src,
    output logic                           busy
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DATA_W = 32;

    logic [NUM_REQ-1:0]   buf_valid;
    logic [RoB_WIDTH-1:0] buf_rob  [NUM_REQ];
    logic [DATA_W-1:0]    buf_data [NUM_REQ];
    logic [DATA_W-1:0]    buf_addr [NUM_REQ];

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic                 any_grant;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   accept;
    logic                 run;

    // Machine advances only when running and not flushing
    assign run = rdy_in & ~RoB_flush_signal;

    // Round-robin search: first occupied buffer at or after rr_ptr
    always_comb begin
        int unsigned idx;
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (run && !any_grant && buf_valid[PTR_W'(idx)]) begin
                any_grant = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
        if (any_grant) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner, wrapping at NUM_REQ
    always_comb begin
        next_ptr = win_idx + PTR_W'(1);
        if (win_idx == PTR_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    // A buffer can take a new result when empty or being drained this cycle
    always_comb begin
        req_ready = {NUM_REQ{run}} & (~buf_valid | grant);
        accept    = req_valid & req_ready;
        busy      = |buf_valid;
    end

    // Holding buffers, round-robin pointer and registered CDB broadcast
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            buf_valid     <= '0;
            rr_ptr        <= '0;
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_data      <= '0;
            cdb_addr      <= '0;
            cdb_src       <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                buf_rob[PTR_W'(i)]  <= '0;
                buf_data[PTR_W'(i)] <= '0;
                buf_addr[PTR_W'(i)] <= '0;
            end
        end else if (rdy_in) begin
            if (RoB_flush_signal) begin
                // Flush discards everything in flight; pointer is kept
                buf_valid <= '0;
                cdb_valid <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (accept[PTR_W'(i)]) begin
                        buf_valid[PTR_W'(i)] <= 1'b1;
                        buf_rob[PTR_W'(i)]   <= req_rob_index[i*RoB_WIDTH +: RoB_WIDTH];
                        buf_data[PTR_W'(i)]  <= req_data[i*DATA_W +: DATA_W];
                        buf_addr[PTR_W'(i)]  <= req_addr[i*DATA_W +: DATA_W];
                    end else if (grant[PTR_W'(i)]) begin
                        buf_valid[PTR_W'(i)] <= 1'b0;
                    end
                end
                if (any_grant) begin
                    cdb_valid     <= 1'b1;
                    cdb_rob_index <= buf_rob[win_idx];
                    cdb_data      <= buf_data[win_idx];
                    cdb_addr      <= buf_addr[win_idx];
                    cdb_src       <= 2'(win_idx);
                    rr_ptr        <= next_ptr;
                end else begin
                    cdb_valid     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single producer, contention, streaming,
// flush, pause and asynchronous reset, with hand-computed expectations.
module tb_cdb_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        RoB_flush_signal;
    logic [2:0]  req_valid;
    logic [8:0]  req_rob_index;
    logic [95:0] req_data;
    logic [95:0] req_addr;
    logic [2:0]  req_ready;
    logic        cdb_valid;
    logic [2:0]  cdb_rob_index;
    logic [31:0] cdb_data;
    logic [31:0] cdb_addr;
    logic [1:0]  cdb_src;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter #(.RoB_WIDTH(3), .NUM_REQ(3)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .RoB_flush_signal (RoB_flush_signal),
        .req_valid        (req_valid),
        .req_rob_index    (req_rob_index),
        .req_data         (req_data),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .cdb_valid        (cdb_valid),
        .cdb_rob_index    (cdb_rob_index),
        .cdb_data         (cdb_data),
        .cdb_addr         (cdb_addr),
        .cdb_src          (cdb_src),
        .busy             (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [2:0] rob, input logic [31:0] d,
                            input logic [31:0] a);
        req_rob_index[i*3 +: 3] = rob;
        req_data[i*32 +: 32]    = d;
        req_addr[i*32 +: 32]    = a;
    endtask

    initial begin
        rst_in           = 1'b1;
        rdy_in           = 1'b1;
        RoB_flush_signal = 1'b0;
        req_valid        = '0;
        req_rob_index    = '0;
        req_data         = '0;
        req_addr         = '0;

        // Reset state
        #12;
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        step();
        rst_in = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h7);

        // Single producer on slot 1
        set_slot(1, 3'd5, 32'hDEADBEEF, 32'h1000_0004);
        req_valid = 3'b010;
        step();
        req_valid = '0;
        check("single_busy", 32'(busy), 32'd1);
        check("single_pre_valid", 32'(cdb_valid), 32'd0);
        step();
        check("single_valid", 32'(cdb_valid), 32'd1);
        check("single_rob", 32'(cdb_rob_index), 32'd5);
        check("single_data", cdb_data, 32'hDEADBEEF);
        check("single_addr", cdb_addr, 32'h1000_0004);
        check("single_src", 32'(cdb_src), 32'd1);
        check("single_rr", 32'(dut.rr_ptr), 32'd2);
        step();
        check("single_drop", 32'(cdb_valid), 32'd0);

        // Move pointer to 0 with a lone grant on slot 2
        set_slot(2, 3'd1, 32'h11, 32'h0);
        req_valid = 3'b100;
        step();
        req_valid = '0;
        step();
        check("wrap_src", 32'(cdb_src), 32'd2);
        check("wrap_rr", 32'(dut.rr_ptr), 32'd0);

        // Contention: all three loaded together, drained 0,1,2
        set_slot(0, 3'd2, 32'h20, 32'h0);
        set_slot(1, 3'd3, 32'h30, 32'h0);
        set_slot(2, 3'd4, 32'h40, 32'h0);
        req_valid = 3'b111;
        step();
        req_valid = '0;
        check("cont_load_valid", 32'(cdb_valid), 32'd0);
        step();
        check("cont_src0", 32'(cdb_src), 32'd0);
        check("cont_rob0", 32'(cdb_rob_index), 32'd2);
        check("cont_busy0", 32'(busy), 32'd1);
        step();
        check("cont_src1", 32'(cdb_src), 32'd1);
        check("cont_rob1", 32'(cdb_rob_index), 32'd3);
        step();
        check("cont_src2", 32'(cdb_src), 32'd2);
        check("cont_rob2", 32'(cdb_rob_index), 32'd4);
        check("cont_busy_end", 32'(busy), 32'd0);
        step();
        check("cont_idle", 32'(cdb_valid), 32'd0);

        // Streaming through slot 0, one result per cycle
        for (int k = 0; k < 8; k++) begin
            set_slot(0, 3'(k), 32'h100 + 32'(k), 32'h0);
            req_valid = 3'b001;
            #1;
            check("stream_ready", 32'(req_ready[0]), 32'd1);
            step();
            if (k > 0) begin
                check("stream_valid", 32'(cdb_valid), 32'd1);
                check("stream_rob", 32'(cdb_rob_index), 32'(k - 1));
            end
        end
        req_valid = '0;
        step();
        check("stream_last_rob", 32'(cdb_rob_index), 32'd7);
        check("stream_last_data", cdb_data, 32'h107);
        step();
        check("stream_idle", 32'(cdb_valid), 32'd0);
        check("stream_rr", 32'(dut.rr_ptr), 32'd1);

        // Flush with slots 0 and 2 pending
        set_slot(0, 3'd6, 32'h60, 32'h0);
        set_slot(2, 3'd7, 32'h70, 32'h0);
        req_valid = 3'b101;
        step();
        req_valid        = '0;
        RoB_flush_signal = 1'b1;
        #1;
        check("flush_ready_low", 32'(req_ready), 32'd0);
        step();
        RoB_flush_signal = 1'b0;
        #1;
        check("flush_valid", 32'(cdb_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(req_ready), 32'h7);
        check("flush_rr", 32'(dut.rr_ptr), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            check("flush_no_bcast", 32'(cdb_valid), 32'd0);
        end

        // Pause with slot 1 pending; inputs offered during the pause are ignored
        set_slot(1, 3'd3, 32'h33, 32'h44);
        req_valid = 3'b010;
        step();
        req_valid = '0;
        rdy_in    = 1'b0;
        set_slot(0, 3'd5, 32'h55, 32'h0);
        req_valid = 3'b001;
        #1;
        check("pause_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("pause_valid", 32'(cdb_valid), 32'd0);
            check("pause_rob", 32'(cdb_rob_index), 32'd7);
            check("pause_data", cdb_data, 32'h107);
            check("pause_rr", 32'(dut.rr_ptr), 32'd1);
            check("pause_bufs", 32'(dut.buf_valid), 32'h2);
        end
        req_valid = '0;
        rdy_in    = 1'b1;
        step();
        check("resume_valid", 32'(cdb_valid), 32'd1);
        check("resume_src", 32'(cdb_src), 32'd1);
        check("resume_rob", 32'(cdb_rob_index), 32'd3);
        check("resume_data", cdb_data, 32'h33);
        check("resume_rr", 32'(dut.rr_ptr), 32'd2);
        step();
        check("resume_idle", 32'(cdb_valid), 32'd0);
        check("resume_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation
        set_slot(0, 3'd1, 32'hA1, 32'hB1);
        set_slot(1, 3'd2, 32'hA2, 32'hB2);
        set_slot(2, 3'd3, 32'hA3, 32'hB3);
        req_valid = 3'b111;
        step();
        step();
        req_valid = '0;
        check("pre_rst_valid", 32'(cdb_valid), 32'd1);
        check("pre_rst_src", 32'(cdb_src), 32'd2);
        check("pre_rst_bufs", 32'(dut.buf_valid), 32'h7);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_valid", 32'(cdb_valid), 32'd0);
        check("arst_rob", 32'(cdb_rob_index), 32'd0);
        check("arst_data", cdb_data, 32'd0);
        check("arst_addr", cdb_addr, 32'd0);
        check("arst_src", 32'(cdb_src), 32'd0);
        check("arst_rr", 32'(dut.rr_ptr), 32'd0);
        check("arst_bufs", 32'(dut.buf_valid), 32'd0);
        step();
        step();
        rst_in = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h7);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
